// File: rtl/btn_debounce_start_if.sv
// Button debouncer signal bundle: the raw button level going in and the
// debounced level, edge strobes and start phase coming out.
interface btn_debounce_start_if;
    logic btn;
    logic db_level;
    logic press_pulse;
    logic release_pulse;
    logic start;

    // Driver side: supplies the raw button and observes the results
    modport master (
        output btn,
        input  db_level,
        input  press_pulse,
        input  release_pulse,
        input  start
    );

    // Debouncer side
    modport slave (
        input  btn,
        output db_level,
        output press_pulse,
        output release_pulse,
        output start
    );
endinterface

// File: rtl/btn_debounce_start.sv
// Push-button debouncer. The raw button is synchronised through two flops, and
// a new level is accepted only after it has held for STABLE_COUNT consecutive
// cycles. Accepted presses toggle the 'start' phase level for the downstream
// 7-segment clock divider.
module btn_debounce_start #(
    parameter int unsigned STABLE_COUNT = 1000000
) (
    input logic                  clock,
    input logic                  resetn,
    btn_debounce_start_if.slave  bus
);

    localparam logic [1:0] LOW       = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] HIGH      = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [20:0] LAST_CNT = 21'(STABLE_COUNT - 1);

    logic        sync1_q, sync2_q;
    logic [1:0]  state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic        db_q, db_d;
    logic        press_q, press_d;
    logic        rel_q, rel_d;
    logic        start_q, start_d;
    logic        s;

    assign s = sync2_q;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: a level must persist through a full count to be accepted
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        start_d = start_q;
        case (state_q)
            LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = HIGH;
                    db_d    = 1'b1;
                    press_d = 1'b1;
                    start_d = ~start_q;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = LOW;
                    db_d    = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 21'd1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            start_q <= start_d;
        end
    end

    assign bus.db_level      = db_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.start         = start_q;

endmodule

// File: tb/tb_btn_debounce_start.sv
// Testbench for btn_debounce_start (STABLE_COUNT = 4). A reference model
// predicts the outputs after every rising edge into a scoreboard queue; a
// monitor on the falling edge pops and compares against the DUT.
module tb_btn_debounce_start;

    localparam int SC = 4;

    typedef struct packed {
        logic db;
        logic pr;
        logic rl;
        logic st;
    } exp_t;

    logic clock;
    logic resetn;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    btn_debounce_start_if bif ();

    btn_debounce_start #(.STABLE_COUNT(SC)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Reference model: the synchronised level is the button two samples ago;
    // a level differing from the accepted one is taken once it has been seen
    // on SC+1 consecutive edges.
    bit [1:0] m_smp;
    bit       m_acc, m_start;
    int       m_run;

    always @(posedge clock) begin
        exp_t e;
        bit   s_now;
        e = '0;
        if (!resetn) begin
            m_smp = '0; m_acc = 0; m_start = 0; m_run = 0;
        end else begin
            s_now = m_smp[1];
            m_smp = {m_smp[0], bif.btn};
            if (s_now != m_acc) m_run++;
            else m_run = 0;
            if (m_run == SC + 1) begin
                m_acc = s_now;
                m_run = 0;
                if (m_acc) begin
                    e.pr = 1'b1;
                    m_start = ~m_start;
                end else begin
                    e.rl = 1'b1;
                end
            end
        end
        e.db = m_acc;
        e.st = m_start;
        sb.push_back(e);
    end

    // Monitor: compare DUT outputs with the predicted response
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("db_level",      32'(bif.db_level),      32'(e.db));
            chk("press_pulse",   32'(bif.press_pulse),   32'(e.pr));
            chk("release_pulse", 32'(bif.release_pulse), 32'(e.rl));
            chk("start",         32'(bif.start),         32'(e.st));
        end
    end

    task automatic hold(input bit v, input int n);
        bif.btn = v;
        repeat (n) @(negedge clock);
    endtask

    // Called aligned to a falling edge: asserts reset mid-cycle, checks the
    // outputs clear without a clock edge, then releases on the next falling edge.
    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        chk("rst_db_level",      32'(bif.db_level),      32'd0);
        chk("rst_press_pulse",   32'(bif.press_pulse),   32'd0);
        chk("rst_release_pulse", 32'(bif.release_pulse), 32'd0);
        chk("rst_start",         32'(bif.start),         32'd0);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        resetn  = 1'b1;
        bif.btn = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        // Clean press and release
        hold(0, 3);
        hold(1, 20);
        hold(0, 20);

        // Bounce before settling high, then low
        hold(1, 3);
        hold(0, 2);
        hold(1, 20);
        hold(0, 20);

        // Press, release, press, then release
        hold(1, 10);
        hold(0, 10);
        hold(1, 10);
        hold(0, 20);

        // Reset mid-debounce (counter at 2) with button still held, which
        // then counts as a fresh press after release
        hold(1, 5);
        do_reset();
        hold(1, 20);
        // Reset while accepted high with start set
        do_reset();
        hold(0, 20);
        do_reset();

        // Fast glitching: every level held under the acceptance window
        for (int i = 0; i < 1000; ) begin
            int n;
            n = $urandom_range(1, 3);
            hold(~bif.btn, n);
            i += n;
        end
        hold(0, 10);
        chk("glitch_db_level", 32'(bif.db_level), 32'd0);
        chk("glitch_start",    32'(bif.start),    32'd0);

        // Random hold lengths straddling the acceptance window
        for (int i = 0; i < 300; i++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
        end
        hold(0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
